// File: rtl/excl_mon_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | excl_mon_pkg: shared types and constants for the violation logger |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package excl_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        HALTED  = 2'd2
    } mon_state_e;

    localparam int c_ts_w_def      = 32;
    localparam int c_cnt_w_def     = 16;
    localparam int c_fifo_depth_def = 4;
    localparam int c_halt_limit_def = 8;

    // Address width for a FIFO of the given depth (at least one bit).
    function automatic int ptr_w(input int depth);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < depth) w = i + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/viol_ts_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | viol_ts_fifo: synchronous DEPTH x WIDTH FIFO for timestamps       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module viol_ts_fifo
    import excl_mon_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [ptr_w(DEPTH):0]   count
);

    localparam int c_aw = ptr_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (c_aw+1)'(DEPTH));
    assign w_pop_ok  = pop && !empty;
    // A pop frees the slot the push will occupy, so full+pop still accepts.
    assign w_push_ok = push && (!full || w_pop_ok);
    assign count     = r_count;
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/excl_violation_logger.sv
`default_nettype none
// +------------------------------------------------------------------+
// | excl_violation_logger: checks a & registered b, counts, stamps    |
// | and queues violation timestamps. Rev 1.0                          |
// +------------------------------------------------------------------+
module excl_violation_logger
    import excl_mon_pkg::*;
#(
    parameter int TS_W       = c_ts_w_def,
    parameter int CNT_W      = c_cnt_w_def,
    parameter int FIFO_DEPTH = c_fifo_depth_def,
    parameter int HALT_LIMIT = c_halt_limit_def
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             en,
    input  logic             clr,
    output logic             viol,
    output logic             fail_flag,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [TS_W-1:0]  first_ts,
    output logic             halted,
    output logic             ts_valid,
    output logic [TS_W-1:0]  ts_data,
    input  logic             ts_ready,
    output logic             ts_drop
);

    localparam int               c_aw      = ptr_w(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    mon_state_e       r_state;
    mon_state_e       w_state_next;
    logic             r_c;
    logic [TS_W-1:0]  r_ts;
    logic             r_viol;
    logic             r_fail;
    logic [CNT_W-1:0] r_cnt;
    logic [TS_W-1:0]  r_first;
    logic             r_drop;
    logic             w_hit;
    logic             w_count;
    logic             w_halt_hit;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [c_aw:0]    w_fifo_cnt;

    assign w_hit   = a & r_c;
    // clr discards a coincident hit.
    assign w_count = (r_state == MONITOR) && w_hit && !clr;
    assign w_pop   = !w_empty && ts_ready;

    generate
        if (HALT_LIMIT != 0) begin : g_halt
            logic [32:0] w_cnt_plus;
            assign w_cnt_plus = 33'(r_cnt) + 33'd1;
            assign w_halt_hit = w_count && (w_cnt_plus >= 33'(HALT_LIMIT));
        end else begin : g_no_halt
            assign w_halt_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = en ? MONITOR : IDLE;
        end else begin
            case (r_state)
                IDLE:    if (en) w_state_next = MONITOR;
                MONITOR: begin
                    if (w_halt_hit)  w_state_next = HALTED;
                    else if (!en)    w_state_next = IDLE;
                end
                HALTED:  w_state_next = HALTED;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_c     <= 1'b0;
            r_ts    <= '0;
        end else begin
            r_state <= w_state_next;
            r_c     <= b;
            r_ts    <= r_ts + TS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_viol  <= 1'b0;
            r_fail  <= 1'b0;
            r_cnt   <= '0;
            r_first <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_viol <= w_count;
            if (w_count) begin
                r_fail <= 1'b1;
                if (!r_fail)             r_first <= r_ts;
                if (r_cnt != c_cnt_max)  r_cnt   <= r_cnt + CNT_W'(1);
                if (w_full && !w_pop)    r_drop  <= 1'b1;
            end
        end
    end

    viol_ts_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TS_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst || clr),
        .push  (w_count),
        .pop   (w_pop),
        .din   (r_ts),
        .dout  (ts_data),
        .full  (w_full),
        .empty (w_empty),
        .count (w_fifo_cnt)
    );

    assign viol      = r_viol;
    assign fail_flag = r_fail;
    assign viol_cnt  = r_cnt;
    assign first_ts  = r_first;
    assign halted    = (r_state == HALTED);
    assign ts_valid  = !w_empty;
    assign ts_drop   = r_drop;

    // A saturated counter can legitimately fall below the FIFO occupancy.
    always_comb begin
        assert #0 (!(ts_valid && $isunknown(ts_data)));
        assert final (r_drop || (r_cnt == c_cnt_max) || (33'(r_cnt) >= 33'(w_fifo_cnt)));
    end

endmodule
`default_nettype wire
